spi_slave_responder: RTL

//  SPI responder: the far end of the SPI link driven by the AHB SPI master peripheral.
//  - Receives MSB-first bytes on MOSI and returns bytes on MISO, all in the HCLK domain.
//  - Byte-wide valid/ready interfaces on both sides.
//  - Used as an on-chip loopback target and as the core of slave-side peripherals.

---
 rtl/spi_slave_responder_pkg.sv | 19 +
 rtl/spi_slave_responder_if.sv | 21 ++
 rtl/spi_slave_responder_sync_edge.sv | 32 +++
 rtl/spi_slave_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared definitions for the SPI responder: byte width, SPI modes and FSM states.
package spi_slave_responder_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_CNT_W  = $clog2(SPI_BYTE_W);

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEL  = 1'b1
    } state_e;

endpackage

// File: rtl/spi_slave_responder_if.sv
// Byte-wide TX/RX valid/ready handshake between the responder and its local user.
interface spi_slave_responder_if;
    import spi_slave_responder_pkg::*;

    logic [SPI_BYTE_W-1:0] tx_data_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic [SPI_BYTE_W-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  rx_ready_i;

    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_data_o, rx_valid_o
    );

    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_data_o, rx_valid_o
    );
endinterface

// File: rtl/spi_slave_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by one-flop rise/fall detection.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level_c;

    assign level_c = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= level_c;
        end
    end

    assign rise_c_o = level_c & ~prev_q;
    assign fall_c_o = ~level_c & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI responder: MSB-first byte exchange with a remote master, oversampled in the HCLK domain.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] TX_IDLE_BYTE = 8'hFF,
    parameter int unsigned           SYNC_STAGES  = 2
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        cpol_i,
    input  logic                        cpha_i,
    input  logic                        SPI_CLK_i,
    input  logic                        SPI_SS_i,
    input  logic                        SPI_MOSI_i,
    output logic                        SPI_MISO_o,
    output logic                        SPI_MISO_oe_o,
    spi_slave_responder_if.slave        bus,
    input  logic                        clr_flags_i,
    output logic                        rx_overrun_o,
    output logic                        tx_underrun_o,
    output logic                        busy_o
);

    logic clk_rise_c, clk_fall_c, ss_rise_c, ss_fall_c;
    logic lead_c, trail_c, sample_c, shift_c, load_c, mosi_c;

    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_e                state_q, state_d;
    logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BYTE_W-1:0] hold_q, hold_d;
    logic                  tx_empty_q, tx_empty_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_done_q, rx_done_d;
    logic                  ovr_q, ovr_d;
    logic                  und_q, und_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;

    // SCLK idles at an unknown level after reset; SS idles high so reset never looks like a select.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
        .clk(HCLK), .rst_n(HRESETn), .d_i(SPI_CLK_i), .rise_c_o(clk_rise_c), .fall_c_o(clk_fall_c)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(HCLK), .rst_n(HRESETn), .d_i(SPI_SS_i), .rise_c_o(ss_rise_c), .fall_c_o(ss_fall_c)
    );

    assign mosi_c   = mosi_sync_q[SYNC_STAGES-1];
    assign lead_c   = cpol_i ? clk_fall_c : clk_rise_c;
    assign trail_c  = cpol_i ? clk_rise_c : clk_fall_c;
    assign sample_c = cpha_i ? trail_c : lead_c;
    assign shift_c  = cpha_i ? lead_c  : trail_c;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            tx_empty_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_done_q   <= 1'b0;
            ovr_q       <= 1'b0;
            und_q       <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI_i};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            tx_empty_q  <= tx_empty_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_done_q   <= rx_done_d;
            ovr_q       <= ovr_d;
            und_q       <= und_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        tx_empty_d = tx_empty_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_done_d  = 1'b0;
        ovr_d      = ovr_q;
        und_d      = und_q;
        oe_d       = oe_q;
        load_c     = 1'b0;

        // Clear first so a coincident flag event below still wins.
        if (clr_flags_i) begin
            ovr_d = 1'b0;
            und_d = 1'b0;
        end

        if (rx_valid_q && bus.rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
        if (rx_done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !bus.rx_ready_i) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (ss_fall_c) begin
                    state_d   = SEL;
                    oe_d      = 1'b1;
                    bit_cnt_d = '0;
                    load_c    = ~cpha_i;
                end
            end
            SEL: begin
                if (ss_rise_c) begin
                    state_d    = IDLE;
                    oe_d       = 1'b0;
                    bit_cnt_d  = '0;
                    tx_shift_d = '0;
                    rx_shift_d = '0;
                end else if (sample_c) begin
                    rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_c};
                    bit_cnt_d  = bit_cnt_q + SPI_CNT_W'(1);
                    rx_done_d  = (bit_cnt_q == SPI_CNT_W'(SPI_BYTE_W-1));
                end else if (shift_c) begin
                    if (bit_cnt_q == '0) begin
                        load_c = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            if (!tx_empty_q) begin
                tx_shift_d = hold_q;
                tx_empty_d = 1'b1;
            end else begin
                tx_shift_d = TX_IDLE_BYTE;
                und_d      = 1'b1;
            end
        end

        // A write racing a load lands in holding for the following byte.
        if (bus.tx_valid_i && tx_empty_q) begin
            hold_d     = bus.tx_data_i;
            tx_empty_d = 1'b0;
        end

        busy_d = (state_d == SEL) && (bit_cnt_d != '0);
    end

    assign SPI_MISO_o     = tx_shift_q[SPI_BYTE_W-1];
    assign SPI_MISO_oe_o  = oe_q;
    assign bus.tx_ready_o = tx_empty_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign rx_overrun_o   = ovr_q;
    assign tx_underrun_o  = und_q;
    assign busy_o         = busy_q;

endmodule
